pipe_hazard_ctrl: RTL

Centralised hazard, forwarding and interlock controller for the 5-stage MIPS pipeline. It replaces the scattered stall/flush logic with one unit and adds three things:
- a configurable no-forwarding mode;
- interlock for a multicycle EX operation (mult/div) of parameterised latency;
- saturating stall/flush performance counters.

It sits beside the ID stage and drives PC, IF/ID, ID/EX and EX/MEM register controls plus the EX operand-forwarding muxes.

---
 rtl/pipe_pkg.sv | 11 +
 rtl/pipe_hazard_ctrl_sat_counter.sv | 14 +
 rtl/pipe_hazard_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared forwarding encodings, FSM states and defaults for the hazard controller.
package pipe_pkg;
    localparam int REGW_DEF = 5;
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB = 2'b01;
    typedef enum logic {S_IDLE, S_RUN} stateT;
    function automatic logic [1:0] fwdSel(input logic memHit, input logic wbHit);
        return memHit ? FWD_MEM : wbHit ? FWD_WB : FWD_REG;
    endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// sat_counter: counter that sticks at all-ones, cleared by async active-low reset.
module sat_counter #(
    parameter int CNTW = 16
) (
    input logic clk,
    input logic reset,
    input logic inc,
    output logic [CNTW-1:0] count
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count <= '0;
        else if (inc && count != '1) count <= count + 1'b1;
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forwarding control for the 5-stage pipeline,
// with multicycle EX interlock and saturating stall/flush counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REGW = REGW_DEF,
    parameter int MC_LAT = 32,
    parameter int CNTW = 16,
    parameter bit FWD_EN = 1'b1
) (
    input logic clk,
    input logic reset,
    input logic [REGW-1:0] id_rs_addr,
    input logic [REGW-1:0] id_rt_addr,
    input logic id_rs_used,
    input logic id_rt_used,
    input logic id_is_branch,
    input logic id_redirect,
    input logic id_mc_op,
    input logic [REGW-1:0] ex_rs_addr,
    input logic [REGW-1:0] ex_rt_addr,
    input logic ex_reg_write,
    input logic ex_mem_read,
    input logic [REGW-1:0] ex_wr_addr,
    input logic mem_reg_write,
    input logic mem_mem_read,
    input logic [REGW-1:0] mem_wr_addr,
    input logic wb_reg_write,
    input logic [REGW-1:0] wb_wr_addr,
    output logic pc_write,
    output logic ifid_write,
    output logic ifid_flush,
    output logic idex_write,
    output logic idex_flush,
    output logic exmem_bubble,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic mc_busy,
    output logic mc_done,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt
);
    localparam int CW = $clog2(MC_LAT);
    stateT state, stateNext;
    logic [CW-1:0] mcCnt;
    logic exMatch, memMatch, hazard, mcLast;
    logic memHitA, memHitB, wbHitA, wbHitB;

    assign exMatch = ex_reg_write && ex_wr_addr != '0 &&
        ((id_rs_used && ex_wr_addr == id_rs_addr) || (id_rt_used && ex_wr_addr == id_rt_addr));
    assign memMatch = mem_reg_write && mem_wr_addr != '0 &&
        ((id_rs_used && mem_wr_addr == id_rs_addr) || (id_rt_used && mem_wr_addr == id_rt_addr));
    // Without forwarding every in-flight producer must drain; WB is covered by the write-first regfile
    assign hazard = FWD_EN ? ((ex_mem_read || id_is_branch) && exMatch) || (id_is_branch && mem_mem_read && memMatch)
                           : exMatch || memMatch;

    assign memHitA = mem_reg_write && mem_wr_addr != '0 && mem_wr_addr == ex_rs_addr;
    assign memHitB = mem_reg_write && mem_wr_addr != '0 && mem_wr_addr == ex_rt_addr;
    assign wbHitA = wb_reg_write && wb_wr_addr != '0 && wb_wr_addr == ex_rs_addr;
    assign wbHitB = wb_reg_write && wb_wr_addr != '0 && wb_wr_addr == ex_rt_addr;
    assign fwd_a = (reset && FWD_EN) ? fwdSel(memHitA, wbHitA) : FWD_REG;
    assign fwd_b = (reset && FWD_EN) ? fwdSel(memHitB, wbHitB) : FWD_REG;

    assign mcLast = mcCnt == '0;
    assign mc_busy = state == S_RUN;

    always_comb begin
        stateNext = state;
        pc_write = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_write = 1'b1;
        idex_flush = 1'b0;
        exmem_bubble = 1'b0;
        mc_done = 1'b0;
        if (!reset) begin
            pc_write = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            exmem_bubble = 1'b1;
        end else if (state == S_RUN) begin
            pc_write = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
            exmem_bubble = !mcLast;
            mc_done = mcLast;
            stateNext = mcLast ? S_IDLE : S_RUN;
        end else begin
            pc_write = !hazard;
            ifid_write = !hazard;
            idex_flush = hazard;
            ifid_flush = !hazard && id_redirect;
            stateNext = (id_mc_op && !hazard) ? S_RUN : S_IDLE;
        end
    end

    // Counter is loaded every idle cycle so RUN always spans exactly MC_LAT cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            mcCnt <= '0;
        end else begin
            state <= stateNext;
            mcCnt <= (state == S_RUN) ? mcCnt - 1'b1 : CW'(MC_LAT - 1);
        end
    end

    sat_counter #(.CNTW(CNTW)) uStallCnt (
        .clk(clk), .reset(reset), .inc(reset && !pc_write), .count(stall_cnt)
    );
    sat_counter #(.CNTW(CNTW)) uFlushCnt (
        .clk(clk), .reset(reset), .inc(reset && ifid_flush), .count(flush_cnt)
    );
endmodule
